// File: rtl/sram_read_arbiter.sv
// Two-port read arbiter for the shared external-SRAM Avalon master. Port 0 is the sprite fetcher and port 1 is the background loader.
// Reads are pipelined, and an ID FIFO steers each return to the port that issued it.
module sram_read_arbiter #(
   parameter int MAX_PENDING  = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_read,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic [3:0]        r0_byteenable,
   output logic              r0_waitrequest,
   output logic [31:0]       r0_readdata,
   output logic              r0_readdatavalid,
   input  logic              r1_read,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic [3:0]        r1_byteenable,
   output logic              r1_waitrequest,
   output logic [31:0]       r1_readdata,
   output logic              r1_readdatavalid,
   input  logic              bg_urgent,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic [3:0]        m_byteenable,
   output logic              m_chipselect,
   input  logic              m_waitrequest,
   input  logic [31:0]       m_readdata,
   input  logic              m_readdatavalid,
   output logic              err_orphan
);

   localparam int PtrW    = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int CntW    = PtrW + 1;
   localparam int StarveW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0]    MaxPend   = CntW'(MAX_PENDING);
   localparam logic [CntW-1:0]    CntOne    = CntW'(1);
   localparam logic [PtrW:0]      PtrOne    = (PtrW + 1)'(1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
   localparam logic [StarveW-1:0] StarveOne = StarveW'(1);

   logic              mRead_q, mRead_d;
   logic [ADDR_W-1:0] mAddr_q, mAddr_d;
   logic [3:0]        mBe_q, mBe_d;
   logic              cmdId_q, cmdId_d;
   logic [CntW-1:0]   outCnt_q, outCnt_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic [PtrW:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic              idMem_q [MAX_PENDING];
   logic              rv0_q, rv0_d, rv1_q, rv1_d;
   logic [31:0]       rdData_q, rdData_d;
   logic              orphan_q, orphan_d;

   logic free, canAccept, grantValid, grantId, accept;
   logic push, pop, fifoNonEmpty, headId;

   assign free         = !mRead_q | !m_waitrequest;
   assign canAccept    = free & (outCnt_q < MaxPend);
   assign fifoNonEmpty = (wrPtr_q != rdPtr_q);
   assign headId       = idMem_q[rdPtr_q[PtrW-1:0]];
   assign push         = mRead_q & !m_waitrequest;
   assign pop          = m_readdatavalid & fifoNonEmpty;
   assign accept       = canAccept & grantValid;

   // Port 1 wins when starved, when its FIFO is urgent, or when port 0 is idle.
   always_comb begin
      grantValid = 1'b0;
      grantId    = 1'b0;
      if (r1_read & ((starve_q == StarveMax) | bg_urgent | !r0_read)) begin
         grantValid = 1'b1;
         grantId    = 1'b1;
      end else if (r0_read) begin
         grantValid = 1'b1;
      end
   end

   always_comb begin
      mRead_d  = mRead_q;
      mAddr_d  = mAddr_q;
      mBe_d    = mBe_q;
      cmdId_d  = cmdId_q;
      if (accept) begin
         mRead_d = 1'b1;
         mAddr_d = grantId ? r1_address : r0_address;
         mBe_d   = grantId ? r1_byteenable : r0_byteenable;
         cmdId_d = grantId;
      end else if (free) begin
         mRead_d = 1'b0;
      end

      outCnt_d = outCnt_q;
      if (accept && !pop) begin
         outCnt_d = outCnt_q + CntOne;
      end else if (!accept && pop) begin
         outCnt_d = outCnt_q - CntOne;
      end

      starve_d = starve_q;
      if (!r1_read) begin
         starve_d = '0;
      end else if (accept && grantId) begin
         starve_d = '0;
      end else if (accept && (starve_q != StarveMax)) begin
         starve_d = starve_q + StarveOne;
      end

      wrPtr_d  = push ? wrPtr_q + PtrOne : wrPtr_q;
      rdPtr_d  = pop ? rdPtr_q + PtrOne : rdPtr_q;
      rv0_d    = pop & !headId;
      rv1_d    = pop & headId;
      rdData_d = m_readdatavalid ? m_readdata : rdData_q;
      orphan_d = orphan_q | (m_readdatavalid & !fifoNonEmpty);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mRead_q  <= 1'b0;
         mAddr_q  <= '0;
         mBe_q    <= '0;
         cmdId_q  <= 1'b0;
         outCnt_q <= '0;
         starve_q <= '0;
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         rdData_q <= '0;
         orphan_q <= 1'b0;
      end else begin
         mRead_q  <= mRead_d;
         mAddr_q  <= mAddr_d;
         mBe_q    <= mBe_d;
         cmdId_q  <= cmdId_d;
         outCnt_q <= outCnt_d;
         starve_q <= starve_d;
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         rv0_q    <= rv0_d;
         rv1_q    <= rv1_d;
         rdData_q <= rdData_d;
         orphan_q <= orphan_d;
      end
   end

   // Storage needs no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         idMem_q[wrPtr_q[PtrW-1:0]] <= cmdId_q;
      end
   end

   assign r0_waitrequest   = !(r0_read & canAccept & grantValid & !grantId);
   assign r1_waitrequest   = !(r1_read & canAccept & grantValid & grantId);
   assign m_read           = mRead_q;
   assign m_chipselect     = mRead_q;
   assign m_address        = mAddr_q;
   assign m_byteenable     = mBe_q;
   assign r0_readdatavalid = rv0_q;
   assign r1_readdatavalid = rv1_q;
   assign r0_readdata      = rdData_q;
   assign r1_readdata      = rdData_q;
   assign err_orphan       = orphan_q;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter. A queue-based reference model and an in-order SRAM model run alongside randomized and directed traffic.
module tb_sram_read_arbiter;

   localparam int MaxPending  = 4;
   localparam int StarveLimit = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0_read = 1'b0, r1_read = 1'b0, bg_urgent = 1'b0;
   logic [31:0] r0_address = '0, r1_address = '0;
   logic [3:0]  r0_byteenable = '0, r1_byteenable = '0;
   logic        r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
   logic [31:0] r0_readdata, r1_readdata, m_address;
   logic        m_read, m_chipselect, err_orphan;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
   logic [31:0] m_readdata = '0;

   sram_read_arbiter #(.MAX_PENDING(MaxPending), .STARVE_LIMIT(StarveLimit), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_read(r0_read), .r0_address(r0_address), .r0_byteenable(r0_byteenable),
      .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
      .r1_read(r1_read), .r1_address(r1_address), .r1_byteenable(r1_byteenable),
      .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
      .bg_urgent(bg_urgent), .m_address(m_address), .m_read(m_read), .m_byteenable(m_byteenable),
      .m_chipselect(m_chipselect), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit doCompare = 1'b0;

   // Stimulus for the next cycle; sRst=1 drives rst_n low.
   bit          sRst, sR0, sR1, sUrg, sWait, sRdv;
   logic [31:0] sA0, sA1, sRdata;
   logic [3:0]  sB0, sB1;

   // Reference model state.
   bit          mdRead, mdId, mdRv0, mdRv1, mdOrphan;
   logic [31:0] mdAddr, mdRdata;
   logic [3:0]  mdBe;
   int          mdOut, mdStarve;
   bit          idQ[$];
   logic [31:0] sramQ[$];
   bit          acc0, acc1;

   function automatic logic [31:0] dataOf(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus();
      rst_n           = !sRst;
      r0_read         = sR0;
      r0_address      = sA0;
      r0_byteenable   = sB0;
      r1_read         = sR1;
      r1_address      = sA1;
      r1_byteenable   = sB1;
      bg_urgent       = sUrg;
      m_waitrequest   = sWait;
      m_readdatavalid = sRdv;
      m_readdata      = sRdata;
   endtask

   task automatic resetModel();
      mdRead = 0; mdId = 0; mdRv0 = 0; mdRv1 = 0; mdOrphan = 0;
      mdAddr = '0; mdRdata = '0; mdBe = '0; mdOut = 0; mdStarve = 0;
      idQ.delete();
   endtask

   // Compare DUT against the model for the current inputs, then advance the model across the next edge.
   task automatic compareAndAdvance();
      bit free, canAcc, masterAcc, nonEmpty, head;
      int w;
      free   = !mdRead || !sWait;
      canAcc = free && (mdOut < MaxPending);
      w = -1;
      if (canAcc) begin
         if (sR1 && ((mdStarve == StarveLimit) || sUrg || !sR0)) w = 1;
         else if (sR0) w = 0;
      end
      if (doCompare) begin
         checkOutput("r0_waitrequest", 32'(r0_waitrequest), 32'(w != 0));
         checkOutput("r1_waitrequest", 32'(r1_waitrequest), 32'(w != 1));
         checkOutput("m_read", 32'(m_read), 32'(mdRead));
         checkOutput("m_chipselect", 32'(m_chipselect), 32'(mdRead));
         checkOutput("m_address", m_address, mdAddr);
         checkOutput("m_byteenable", 32'(m_byteenable), 32'(mdBe));
         checkOutput("r0_readdatavalid", 32'(r0_readdatavalid), 32'(mdRv0));
         checkOutput("r1_readdatavalid", 32'(r1_readdatavalid), 32'(mdRv1));
         checkOutput("r0_readdata", r0_readdata, mdRdata);
         checkOutput("r1_readdata", r1_readdata, mdRdata);
         checkOutput("err_orphan", 32'(err_orphan), 32'(mdOrphan));
      end
      masterAcc = mdRead && !sWait;
      if (masterAcc) sramQ.push_back(mdAddr);
      if (sRst) begin
         resetModel();
         acc0 = 0;
         acc1 = 0;
         return;
      end
      acc0 = (w == 0);
      acc1 = (w == 1);
      nonEmpty = idQ.size() > 0;
      head = nonEmpty ? idQ[0] : 1'b0;
      mdRv0 = sRdv && nonEmpty && !head;
      mdRv1 = sRdv && nonEmpty && head;
      if (sRdv) mdRdata = sRdata;
      if (sRdv && !nonEmpty) mdOrphan = 1;
      if (sRdv && nonEmpty) begin
         void'(idQ.pop_front());
         mdOut--;
      end
      if (masterAcc) idQ.push_back(mdId);
      if (w >= 0) begin
         mdOut++;
         mdRead = 1;
         mdAddr = (w == 1) ? sA1 : sA0;
         mdBe   = (w == 1) ? sB1 : sB0;
         mdId   = (w == 1);
      end else if (free) begin
         mdRead = 0;
      end
      if (!sR1) mdStarve = 0;
      else if (w == 1) mdStarve = 0;
      else if (w == 0 && mdStarve < StarveLimit) mdStarve++;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      applyStimulus();
      @(negedge clk);
      compareAndAdvance();
   endtask

   task automatic sramReturn(input int pRet);
      if (sramQ.size() > 0 && $urandom_range(99) < pRet) begin
         sRdv = 1;
         sRdata = dataOf(sramQ.pop_front());
      end else begin
         sRdv = 0;
         sRdata = $urandom();
      end
   endtask

   // Port addresses carry the port number in bit 31; a pending request is held until accepted.
   task automatic randomInputs(input int pR0, input int pR1, input int pWait, input int pRet, input int pUrg);
      logic [31:0] t;
      sRst = 0;
      if (!(sR0 && !acc0)) begin
         t = $urandom();
         sR0 = $urandom_range(99) < pR0;
         sA0 = {1'b0, t[30:0]};
         sB0 = 4'($urandom());
      end
      if (!(sR1 && !acc1)) begin
         t = $urandom();
         sR1 = $urandom_range(99) < pR1;
         sA1 = {1'b1, t[30:0]};
         sB1 = 4'($urandom());
      end
      sWait = $urandom_range(99) < pWait;
      sUrg  = $urandom_range(99) < pUrg;
      sramReturn(pRet);
   endtask

   task automatic drain();
      int n;
      n = 0;
      sR0 = 0; sR1 = 0; sUrg = 0; sRst = 0;
      while ((sramQ.size() > 0 || mdOut > 0 || mdRead) && n < 60) begin
         sWait = 0;
         sramReturn(100);
         stepCycle();
         n++;
      end
      sWait = 0; sRdv = 0;
      stepCycle();
      checkOutput("drain_timeout", 32'(n >= 60), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int obs, mCount;
      bit ports[$];
      logic [31:0] datas[$];
      logic [31:0] addrs[$];
      sR0 = 0; sR1 = 0; sUrg = 0; sWait = 0; sRdv = 0; sRst = 1;
      sA0 = '0; sA1 = '0; sB0 = '0; sB1 = '0; sRdata = '0;
      acc0 = 0; acc1 = 0;
      resetModel();
      stepCycle();
      stepCycle();
      doCompare = 1;
      sRst = 0;
      stepCycle();
      $display("[TB] reset state checked");

      // Single port 0 read with a hand-timed return.
      drain();
      sR0 = 1; sA0 = 32'h100; sB0 = 4'hF;
      stepCycle();
      checkOutput("t2_accept", 32'(r0_waitrequest), 32'd0);
      sR0 = 0;
      mCount = 0;
      stepCycle();
      mCount += int'(m_read);
      checkOutput("t2_m_address", m_address, 32'h100);
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         mCount += int'(m_read);
      end
      sRdv = 1; sRdata = 32'hAABBCCDD;
      void'(sramQ.pop_front());
      stepCycle();
      mCount += int'(m_read);
      checkOutput("t2_m_read_cycles", 32'(mCount), 32'd1);
      sRdv = 0;
      stepCycle();
      checkOutput("t2_r0_rdv", 32'(r0_readdatavalid), 32'd1);
      checkOutput("t2_r0_data", r0_readdata, 32'hAABBCCDD);
      checkOutput("t2_r1_rdv", 32'(r1_readdatavalid), 32'd0);

      // Continuous contention: every ninth issue must belong to port 1.
      drain();
      sR0 = 0; sR1 = 0;
      ports.delete();
      for (int i = 0; i < 40 && ports.size() < 18; i++) begin
         randomInputs(100, 100, 0, 100, 0);
         stepCycle();
         if (m_read) ports.push_back(m_address[31]);
      end
      checkOutput("t3_issue_count", 32'(ports.size()), 32'd18);
      if (ports.size() >= 18) begin
         checkOutput("t3_issue1", 32'(ports[0]), 32'd0);
         checkOutput("t3_issue8", 32'(ports[7]), 32'd0);
         checkOutput("t3_issue9", 32'(ports[8]), 32'd1);
         checkOutput("t3_issue10", 32'(ports[9]), 32'd0);
         checkOutput("t3_issue18", 32'(ports[17]), 32'd1);
      end

      // Pending limit with an SRAM that stalls its returns.
      drain();
      obs = 0;
      for (int i = 0; i < 10; i++) begin
         randomInputs(100, 100, 0, 0, 0);
         stepCycle();
         obs += int'((r0_read && !r0_waitrequest) || (r1_read && !r1_waitrequest));
      end
      checkOutput("t4_accepts_full", 32'(obs), 32'(MaxPending));
      checkOutput("t4_w0_full", 32'(r0_waitrequest), 32'd1);
      checkOutput("t4_w1_full", 32'(r1_waitrequest), 32'd1);
      for (int i = 0; i < 7; i++) begin
         randomInputs(100, 100, 0, (i == 0) ? 100 : 0, 0);
         stepCycle();
         obs += int'((r0_read && !r0_waitrequest) || (r1_read && !r1_waitrequest));
      end
      checkOutput("t4_accepts_after_return", 32'(obs), 32'(MaxPending + 1));

      // SRAM stall: the command must stay put while port 1 waits behind it.
      drain();
      sR1 = 1; sA1 = 32'h8000_1234; sB1 = 4'hC;
      stepCycle();
      sA1 = 32'h8000_5678; sB1 = 4'h3; sWait = 1;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkOutput("t5_addr_stable", m_address, 32'h8000_1234);
         checkOutput("t5_be_stable", 32'(m_byteenable), 32'hC);
         checkOutput("t5_r1_wait", 32'(r1_waitrequest), 32'd1);
      end
      sWait = 0;
      stepCycle();
      checkOutput("t5_addr_last", m_address, 32'h8000_1234);
      checkOutput("t5_r1_accept", 32'(r1_waitrequest), 32'd0);
      sR1 = 0;

      // Interleaved issue with bg_urgent toggling; returns must come back in issue order.
      drain();
      addrs.delete();
      for (int i = 0; i < 4; i++) begin
         sR0 = (i % 2 == 0); sR1 = (i % 2 == 1); sUrg = (i % 2 == 0);
         sA0 = 32'h0000_0200 + 32'(i); sA1 = 32'h8000_0300 + 32'(i);
         sB0 = 4'hF; sB1 = 4'hF; sWait = 0; sRdv = 0;
         addrs.push_back((i % 2 == 0) ? sA0 : sA1);
         stepCycle();
      end
      sR0 = 0; sR1 = 0;
      ports.delete();
      datas.delete();
      for (int i = 0; i < 20 && ports.size() < 4; i++) begin
         randomInputs(0, 0, 20, 60, 50);
         stepCycle();
         if (r0_readdatavalid || r1_readdatavalid) begin
            ports.push_back(r1_readdatavalid);
            datas.push_back(r0_readdatavalid ? r0_readdata : r1_readdata);
         end
      end
      checkOutput("t6_return_count", 32'(ports.size()), 32'd4);
      for (int i = 0; i < 4 && i < ports.size(); i++) begin
         checkOutput("t6_port", 32'(ports[i]), 32'(i % 2));
         checkOutput("t6_data", datas[i], dataOf(addrs[i]));
      end

      // Reset with three reads in flight; their late returns must be flagged as orphans.
      drain();
      for (int i = 0; i < 3; i++) begin
         sR0 = 1; sA0 = 32'h0000_0400 + 32'(i); sB0 = 4'h5; sWait = 0; sRdv = 0;
         stepCycle();
      end
      sR0 = 0;
      stepCycle();
      sRst = 1;
      stepCycle();
      sRst = 0;
      stepCycle();
      checkOutput("t1_m_read", 32'(m_read), 32'd0);
      checkOutput("t1_orphan_clear", 32'(err_orphan), 32'd0);
      checkOutput("t1_inflight", 32'(sramQ.size()), 32'd3);
      sramReturn(100);
      stepCycle();
      sRdv = 0;
      stepCycle();
      checkOutput("t1_orphan_set", 32'(err_orphan), 32'd1);
      sRst = 1;
      stepCycle();
      sramQ.delete();
      sRst = 0;
      stepCycle();

      // Randomized mixed traffic.
      for (int i = 0; i < 2000; i++) begin
         if (i < 700) randomInputs(60, 50, 30, 40, 30);
         else if (i < 1400) randomInputs(90, 90, 10, 70, 10);
         else randomInputs(40, 80, 50, 25, 60);
         stepCycle();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Shares the single external-SRAM Avalon read master between two requesters.
- Port 0 is the sprite pixel fetcher, which is pixel-time critical. Port 1 is the background line loader that fills the background FIFO.
- Registers commands, issues pipelined reads (up to MAX_PENDING in flight) and routes each readdatavalid back to its originator in order via an ID FIFO.
- Sits between the composer's fetch logic and the SRAM bridge.

Parameters:
- MAX_PENDING, 4, maximum accepted-but-unreturned reads, counting the one held in the command register; power of two, 2..16.
- STARVE_LIMIT, 8, consecutive lost arbitrations by port 1 before port 1 is forced a grant.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- r0_read  in  1  port 0 read request
- r0_address  in  ADDR_W  port 0 word address
- r0_byteenable  in  4  port 0 byte enables
- r0_waitrequest  out  1  port 0 command not accepted this cycle
- r0_readdata  out  32  port 0 return data
- r0_readdatavalid  out  1  port 0 return strobe
- r1_read, r1_address, r1_byteenable, r1_waitrequest, r1_readdata, r1_readdatavalid: same as port 0, for port 1
- bg_urgent  in  1  background FIFO below its low watermark
- m_address  out  ADDR_W  to SRAM
- m_read  out  1  to SRAM
- m_byteenable  out  4  to SRAM
- m_chipselect  out  1  to SRAM; always equal to m_read
- m_waitrequest  in  1  from SRAM
- m_readdata  in  32  from SRAM
- m_readdatavalid  in  1  from SRAM
- err_orphan  out  1  sticky: readdatavalid arrived with no read outstanding

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - m_read, m_chipselect, both rN_readdatavalid, err_orphan, outstanding count, ID FIFO, starve counter all = 0.
  - m_address, m_byteenable, rN_readdata = 0.
  - Reads in flight are discarded; returns arriving after reset set err_orphan.
- Command register:
  - free = !m_read | !m_waitrequest.
  - can_accept = free & (outstanding < MAX_PENDING).
  - When can_accept and a request wins arbitration, latch {address, byteenable, id}, set m_read=1 next cycle. Latency is 1 cycle from request to m_read.
  - If no request wins while free, m_read clears to 0 next cycle.
  - m_address and m_byteenable hold stable while m_read=1 and m_waitrequest=1.
- Requester handshake:
  - rN_waitrequest = !(rN_read & can_accept & grant==N). This is combinational, Avalon style.
  - A request is accepted on a cycle where rN_read=1 and rN_waitrequest=0.
  - The requester must hold its address and byteenable while waiting.
- Arbitration (when can_accept):
  - Forced port 1: starve counter == STARVE_LIMIT and r1_read=1.
  - Otherwise, if bg_urgent=1: port 1 wins, port 0 loses.
  - Otherwise: port 0 wins, port 1 loses.
  - A single requester always wins.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when r1_read=1, can_accept=1 and port 0 was granted.
  - Clears on any port 1 grant, and when r1_read=0.
- Outstanding count:
  - +1 on each requester accept; −1 on m_readdatavalid with a nonempty ID FIFO.
  - Accept and return in the same cycle leave the count unchanged.
- ID FIFO:
  - Depth MAX_PENDING; push the id when the master accepts (m_read & !m_waitrequest).
  - Pop on m_readdatavalid.
  - Push and pop in the same cycle are both performed.
- Return path (registered, 1-cycle latency):
  - rN_readdatavalid <= m_readdatavalid & fifo_nonempty & (head_id==N).
  - Both rN_readdata <= m_readdata on every valid; data is ignored when the strobe is low.
- Orphan return: m_readdatavalid with an empty ID FIFO is dropped; err_orphan <= 1 until reset.
- Returns are in order; the SRAM is required to return data in issue order.

Test Plan:
1. Reset mid-traffic: 3 reads outstanding, rst_n=0 for 1 cycle -> m_read=0, waitrequests are the combinational function, count=0; a subsequent m_readdatavalid sets err_orphan=1.
2. Single port 0 read of addr 0x100, m_waitrequest=0, data returned 3 cycles later as 0xAABBCCDD -> m_read high exactly 1 cycle at 0x100; r0_readdatavalid=1 with 0xAABBCCDD one cycle after return; r1_readdatavalid stays 0.
3. Both ports request continuously, bg_urgent=0, STARVE_LIMIT=8 -> 8 port 0 grants, then 1 port 1 grant, pattern repeats; the 9th issued address is port 1's.
4. MAX_PENDING=4, SRAM never returns -> after 4 accepts both rN_waitrequest=1; one return -> exactly one more accept.
5. m_waitrequest held high 5 cycles with port 1 pending -> m_address/m_byteenable stable 6 cycles; r1_waitrequest=1 throughout.
6. Interleaved issue P0,P1,P0,P1 with bg_urgent toggling -> returns routed P0,P1,P0,P1 with the matching data words.
